// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 set-2 scancode constants, direction encoding and key-mapping helpers
// for the keyboard decoder and any downstream movement logic.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [2:0] {
    DIR_STILL = 3'd0,
    DIR_UP    = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } state_e;

  // Physical key index: idx[1:0] selects up/left/down/right, idx[2] marks the arrow-key bank.
  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_lookup_t;

  function automatic key_lookup_t lookup_key(input logic [7:0] code, input logic ext);
    key_lookup_t r;
    r.hit = 1'b1;
    r.idx = 3'd0;
    if (!ext) begin
      case (code)
        SC_W:    r.idx = 3'd0;
        SC_A:    r.idx = 3'd1;
        SC_S:    r.idx = 3'd2;
        SC_D:    r.idx = 3'd3;
        default: r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_UP:    r.idx = 3'd4;
        SC_LEFT:  r.idx = 3'd5;
        SC_DOWN:  r.idx = 3'd6;
        SC_RIGHT: r.idx = 3'd7;
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [2:0] key_dir(input logic [2:0] idx);
    return {1'b0, idx[1:0]} + 3'd1;
  endfunction

  function automatic logic [3:0] fold_held(input logic [7:0] keys);
    return keys[7:4] | keys[3:0];
  endfunction

  function automatic logic [2:0] pick_dir(input logic [3:0] held);
    if (held[0])      return DIR_UP;
    else if (held[1]) return DIR_LEFT;
    else if (held[2]) return DIR_DOWN;
    else if (held[3]) return DIR_RIGHT;
    else              return DIR_STILL;
  endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Idle-cycle watchdog for partially received prefix sequences; expired pulses
// after TIMEOUT_CYCLES consecutive run cycles with no clear.
module ps2_prefix_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = run && !clear && (count_q == LAST);

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || !run || expired) count_d = '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 decoder for WASD and arrow keys: tracks eight held keys and
// produces a held-direction bitmap, current direction and make/break events.
module ps2_key_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_data_en,
  output logic [3:0] key_held,
  output logic [2:0] dir,
  output logic       key_event,
  output logic [2:0] key_code,
  output logic       key_make
);

  state_e      state_q, state_d;
  logic [7:0]  keys_q, keys_d;
  logic [3:0]  held_q, held_d;
  logic [2:0]  dir_q, dir_d;
  logic        event_q, event_d;
  logic [2:0]  code_q, code_d;
  logic        make_q, make_d;

  logic        expired;
  logic        do_decode, is_ext, is_break;
  key_lookup_t lk;
  logic [2:0]  kdir;
  logic [3:0]  held_after;

  ps2_prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .clear  (ps2_data_en),
    .run    (state_q != ST_IDLE),
    .expired(expired)
  );

  always_comb begin
    state_d    = state_q;
    keys_d     = keys_q;
    dir_d      = dir_q;
    event_d    = 1'b0;
    code_d     = code_q;
    make_d     = make_q;
    do_decode  = 1'b0;
    is_ext     = 1'b0;
    is_break   = 1'b0;
    held_after = fold_held(keys_q);

    // A byte on the expiry cycle takes precedence over the timeout.
    if (ps2_data_en) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_data == SC_E0)      state_d = ST_GOT_E0;
          else if (ps2_data == SC_F0) state_d = ST_GOT_F0;
          else                        do_decode = 1'b1;
        end
        ST_GOT_E0: begin
          if (ps2_data == SC_F0)      state_d = ST_GOT_E0F0;
          else if (ps2_data != SC_E0) begin
            do_decode = 1'b1;
            is_ext    = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          if (ps2_data == SC_E0)      state_d = ST_GOT_E0;
          else if (ps2_data != SC_F0) begin
            do_decode = 1'b1;
            is_break  = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          if (ps2_data == SC_E0)      state_d = ST_GOT_E0;
          else if (ps2_data != SC_F0) begin
            do_decode = 1'b1;
            is_ext    = 1'b1;
            is_break  = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      endcase
    end else if (expired) begin
      state_d = ST_IDLE;
    end

    lk   = lookup_key(ps2_data, is_ext);
    kdir = key_dir(lk.idx);

    if (do_decode && lk.hit) begin
      if (!is_break && !keys_q[lk.idx]) begin
        keys_d[lk.idx] = 1'b1;
        dir_d          = kdir;
        event_d        = 1'b1;
        code_d         = kdir;
        make_d         = 1'b1;
      end else if (is_break && keys_q[lk.idx]) begin
        keys_d[lk.idx] = 1'b0;
        event_d        = 1'b1;
        code_d         = kdir;
        make_d         = 1'b0;
        held_after     = fold_held(keys_d);
        if (!held_after[lk.idx[1:0]] && (dir_q == kdir)) dir_d = pick_dir(held_after);
      end
    end

    held_d = fold_held(keys_d);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      keys_q  <= '0;
      held_q  <= '0;
      dir_q   <= DIR_STILL;
      event_q <= 1'b0;
      code_q  <= DIR_STILL;
      make_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
      held_q  <= held_d;
      dir_q   <= dir_d;
      event_q <= event_d;
      code_q  <= code_d;
      make_q  <= make_d;
    end
  end

  assign key_held  = held_q;
  assign dir       = dir_q;
  assign key_event = event_q;
  assign key_code  = code_q;
  assign key_make  = make_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2_500_000, meaning max cycles between prefix byte and code byte (50 ms at 50 MHz).
REQ-002 SHALL have port clock  in  1  system clock (CLOCK_50); one clock only.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ps2_data  in  8  received PS/2 set-2 byte from PS2_Controller.
REQ-005 SHALL have port ps2_data_en  in  1  one-cycle strobe; ps2_data valid when high.
REQ-006 SHALL have port key_held  out  4  held bitmap {right,down,left,up}; bit set while any key mapped to that direction is held.
REQ-007 SHALL have port dir  out  3  current direction: still=000, up=001, left=010, down=011, right=100.
REQ-008 SHALL have port key_event  out  1  one-cycle strobe on each accepted make/break.
REQ-009 SHALL have port key_code  out  3  direction code of the last event (encoding as dir).
REQ-010 SHALL have port key_make  out  1  1 = make, 0 = break, for the last event.

Function
REQ-011 SHALL map codes: W 0x1D, A 0x1C, S 0x1B, D 0x23 (plain); up E0 75, left E0 6B, down E0 72, right E0 74 (extended).
REQ-012 SHALL track eight physical keys internally; key_held[d] = OR of the two keys mapped to direction d.
REQ-013 SHALL run FSM states IDLE, GOT_E0, GOT_F0, GOT_E0F0; bytes consumed only when ps2_data_en=1.
REQ-014 IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; other -> plain make decode, stay IDLE.
REQ-015 GOT_E0: 0xF0 -> GOT_E0F0; 0xE0 -> stay; other -> extended make decode, IDLE.
REQ-016 GOT_F0: 0xE0 -> GOT_E0 (resync); 0xF0 -> stay; other -> plain break decode, IDLE.
REQ-017 GOT_E0F0: 0xE0 -> GOT_E0; 0xF0 -> stay; other -> extended break decode, IDLE.
REQ-018 Unmapped codes SHALL produce no event and no state change to held/dir.
REQ-019 Make of a key not already held SHALL set its held bit, set dir to its direction, pulse key_event with key_make=1.
REQ-020 Make of an already-held key (typematic repeat) SHALL produce no event and leave dir unchanged.
REQ-021 Break of a held key SHALL clear its bit and pulse key_event with key_make=0; if that direction is no longer held and equals dir, dir SHALL become the highest-priority held direction (up>left>down>right), else still.
REQ-022 Break of a key not held SHALL be ignored (no event).
REQ-023 All outputs SHALL be registered and update on the clock edge following the ps2_data_en cycle (latency 1).
REQ-024 key_event SHALL be high exactly one cycle per accepted event.
REQ-025 In any non-IDLE state, TIMEOUT_CYCLES cycles without ps2_data_en SHALL return FSM to IDLE with no event; counter clears on each accepted byte.
REQ-026 Byte arriving on the same cycle the timeout expires SHALL be processed in the current state (byte wins).

Reset
REQ-027 On resetn=0, asynchronously: FSM=IDLE, held keys=0, key_held=0000, dir=000, key_event=0, key_code=000, key_make=0, timeout counter=0.
REQ-028 Reset mid-sequence (e.g. after 0xE0) SHALL discard the partial sequence; next byte decoded from IDLE.

Structure
REQ-029 Package ps2_kbd_pkg SHALL hold scancode constants (0xE0, 0xF0, eight key codes) and the 3-bit direction encoding, shared with movement logic.
REQ-030 Timeout counter SHALL be sub-module ps2_prefix_timer (inputs clock, resetn, start/clear, run; output expired).

Verification
REQ-031 1D -> key_event, key_code=001, key_make=1, dir=001, key_held=0001; then F0 1D -> key_make=0, dir=000, key_held=0000.
REQ-032 1D, 23 (W then D held) -> dir=100; F0 23 -> dir=001; F0 1D -> dir=000.
REQ-033 E0 6B -> dir=010; E0 F0 6B -> dir=000; E0 6B repeated 3 times -> exactly one key_event.
REQ-034 1D and E0 75 held, F0 1D -> key_event pulse, key_held[0]=1 still, dir=001.
REQ-035 E0 then idle TIMEOUT_CYCLES (use 100 in bench), then 75 -> decoded as plain 0x75, unmapped, no event, dir unchanged.
REQ-036 resetn low after E0 F0 while 1C held -> all outputs 0; next 6B -> no event (plain 6B unmapped).
